restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL declare parameters: DW = 8 (dividend/quotient width); VW = 4 (divisor/remainder width).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, DW: signed two's-complement dividend.
REQ-006 SHALL have port divisor, input, VW: signed two's-complement divisor.
REQ-007 SHALL have port quotient, output, DW: signed quotient, truncated toward zero.
REQ-008 SHALL have port remainder, output, VW: signed remainder, same sign as dividend (or zero).
REQ-009 SHALL have port busy, output, 1: high from the cycle after start is accepted until done rises.
REQ-010 SHALL have port done, output, 1: level signal; stays high until the next accepted start or reset.
REQ-011 SHALL have port div_by_zero, output, 1: divisor was zero; valid while done is high.
REQ-012 SHALL have port overflow, output, 1: true quotient not representable in DW bits; valid while done is high.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, ITER, FIX, DONE.
REQ-014 IDLE/DONE with start=1 at edge k: latch operands, clear done and both flags, go to LOAD.
REQ-015 LOAD: store |dividend| as DW+1-bit unsigned and |divisor| as VW+1-bit unsigned.
REQ-016 LOAD: record sign_q = dividend[DW-1] XOR divisor[VW-1] and sign_r = dividend[DW-1].
REQ-017 LOAD: clear the partial remainder and iteration counter, then go to ITER.
REQ-018 LOAD with divisor == 0: go directly to DONE with quotient = all ones, remainder = 0, div_by_zero = 1; done visible after edge k+2.
REQ-019 ITER, each cycle: shift {partial remainder, quotient magnitude} left by one.
REQ-020 ITER, each cycle: trial-subtract |divisor|; if the result is non-negative, keep it and set the quotient LSB to 1, else restore and set the LSB to 0.
REQ-021 ITER SHALL run exactly DW cycles, counter 0..DW-1, then go to FIX.
REQ-022 FIX: negate the quotient magnitude if sign_q, negate the remainder if sign_r, truncate to DW/VW bits, go to DONE.
REQ-023 Normal latency: start sampled at edge k gives done = 1 and valid results after edge k+DW+2 (k+10 for DW = 8).
REQ-024 overflow SHALL be 1 only for dividend = most-negative value and divisor = -1; quotient then reads 8'h80 and remainder 0.
REQ-025 |remainder| < |divisor| <= 2^(VW-1), so remainder SHALL always fit VW signed bits without saturation.
REQ-026 start SHALL be ignored in LOAD, ITER and FIX; operand changes during busy SHALL have no effect.
REQ-027 quotient and remainder SHALL hold their last values in DONE and IDLE and change only in FIX, or in LOAD on divide-by-zero.
REQ-028 busy and done SHALL never be high in the same cycle.

Reset
REQ-029 reset = 1 at any edge, including mid-operation: FSM to IDLE; quotient, remainder, busy, done, div_by_zero, overflow all 0.
REQ-030 reset SHALL take priority over start in the same cycle.
REQ-031 No latches; every flop SHALL be reset synchronously.

Structure
REQ-032 Shared package div_pkg SHALL hold DW, VW, the state enum typedef and the ITER counter width ($clog2(DW)).
REQ-033 One combinational sub-module, twos_abs (parameterised width; abs and conditional negate), SHALL be instantiated for LOAD and FIX.

Verification
REQ-034 Bench SHALL cover: 100 / 7 -> quotient 8'h0E, remainder 4'h2, done after exactly 10 cycles, flags 0.
REQ-035 Bench SHALL cover: -100 / 7 -> quotient 8'hF2 (-14), remainder 4'hE (-2); and 100 / -8 -> quotient 8'hF4 (-12), remainder 4'h4.
REQ-036 Bench SHALL cover: 5 / 0 -> div_by_zero = 1, quotient 8'hFF, remainder 4'h0, done 2 cycles after start.
REQ-037 Bench SHALL cover: -128 / -1 -> overflow = 1, quotient 8'h80, remainder 4'h0.
REQ-038 Bench SHALL cover: start during ITER with new operands -> ignored, original result returned; and reset asserted in ITER cycle 4 -> all outputs 0 next cycle, then a fresh 7 / 2 -> quotient 3, remainder 1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared widths, FSM state encoding and iteration counter width for the restoring divider.
package div_pkg;

    localparam int DW    = 8;
    localparam int VW    = 4;
    localparam int CNT_W = $clog2(DW);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/twos_abs.sv
// Two's-complement conditional negate; drive negate with the sign bit to get |value|.
module twos_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle signed restoring divider: magnitudes are divided one bit per cycle,
// then signs are re-applied (quotient truncates toward zero, remainder follows dividend).
module restoring_divider #(
    parameter int DW = div_pkg::DW,
    parameter int VW = div_pkg::VW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic          overflow
);
    import div_pkg::*;

    state_t           state;
    logic [DW-1:0]    dvd_q;
    logic [VW-1:0]    dvs_q;
    logic [DW-1:0]    qm;
    logic [VW-1:0]    pr;
    logic [VW:0]      dmag;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;
    logic             ovf_pend;

    logic [DW-1:0]    dvd_mag;
    logic [VW-1:0]    dvs_mag;
    logic [DW-1:0]    q_fix;
    logic [VW-1:0]    r_fix;
    logic [VW:0]      shifted;
    logic [VW:0]      diff;
    logic             ge;
    logic             accept;

    twos_abs #(.W(DW)) u_abs_dvd (
        .value  (dvd_q),
        .negate (dvd_q[DW-1]),
        .result (dvd_mag)
    );

    twos_abs #(.W(VW)) u_abs_dvs (
        .value  (dvs_q),
        .negate (dvs_q[VW-1]),
        .result (dvs_mag)
    );

    twos_abs #(.W(DW)) u_neg_q (
        .value  (qm),
        .negate (sign_q),
        .result (q_fix)
    );

    twos_abs #(.W(VW)) u_neg_r (
        .value  (pr),
        .negate (sign_r),
        .result (r_fix)
    );

    // The partial remainder stays below |divisor| <= 2^(VW-1), so VW bits hold it.
    assign shifted = {pr, qm[DW-1]};
    assign ge      = (shifted >= dmag);
    assign diff    = shifted - dmag;

    // In DONE with busy still high the zero-divisor result is being published this cycle.
    assign accept  = start && ((state == IDLE) || (state == DONE && !busy));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            qm          <= '0;
            pr          <= '0;
            dmag        <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (accept) begin
                        dvd_q       <= dividend;
                        dvs_q       <= divisor;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    // |most-negative| still fits DW bits when read as unsigned.
                    qm       <= dvd_mag;
                    dmag     <= {1'b0, dvs_mag};
                    sign_q   <= dvd_q[DW-1] ^ dvs_q[VW-1];
                    sign_r   <= dvd_q[DW-1];
                    ovf_pend <= (dvd_q == {1'b1, {(DW-1){1'b0}}}) && (dvs_q == '1);
                    pr       <= '0;
                    cnt      <= '0;
                    if (dvs_q == '0) begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state       <= ITER;
                    end
                end
                ITER: begin
                    pr  <= VW'(ge ? diff : shifted);
                    qm  <= {qm[DW-2:0], ge};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DW - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    overflow  <= ovf_pend;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench: the driver queues hand-computed results, a monitor checks them on done.
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       overflow;

    restoring_divider #(.DW(8), .VW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ovf;
        int         lat;
        int         k;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Issue one start pulse; returns at the negedge following the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b, input bit push,
                         input string nm, input logic [7:0] q, input logic [3:0] r,
                         input logic dz, input logic ovf, input int lat);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) begin
            e.name = nm; e.q = q; e.r = r; e.dz = dz; e.ovf = ovf; e.lat = lat;
            e.k    = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done=%0b required 1", nm, done);
        end
        @(negedge clk);
    endtask

    // Monitor: compare the head of the scoreboard on every rising edge of done.
    initial begin
        exp_t e;
        logic done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && done) chk("busy_and_done", 1, 0);
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, " quotient"}, int'(quotient), int'(e.q));
                    chk({e.name, " remainder"}, int'(remainder), int'(e.r));
                    chk({e.name, " div_by_zero"}, int'(div_by_zero), int'(e.dz));
                    chk({e.name, " overflow"}, int'(overflow), int'(e.ovf));
                    chk({e.name, " latency"}, cyc - e.k, e.lat);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, " quotient"}, int'(quotient), 0);
        chk({nm, " remainder"}, int'(remainder), 0);
        chk({nm, " busy"}, int'(busy), 0);
        chk({nm, " done"}, int'(done), 0);
        chk({nm, " div_by_zero"}, int'(div_by_zero), 0);
        chk({nm, " overflow"}, int'(overflow), 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        issue(8'd100, 4'd7, 1'b1, "100/7", 8'h0E, 4'h2, 1'b0, 1'b0, 10);
        wait_done("100/7");
        issue(8'h9C, 4'd7, 1'b1, "-100/7", 8'hF2, 4'hE, 1'b0, 1'b0, 10);
        wait_done("-100/7");
        issue(8'd100, 4'h8, 1'b1, "100/-8", 8'hF4, 4'h4, 1'b0, 1'b0, 10);
        wait_done("100/-8");
        issue(8'd5, 4'h0, 1'b1, "5/0", 8'hFF, 4'h0, 1'b1, 1'b0, 2);
        wait_done("5/0");
        issue(8'h80, 4'hF, 1'b1, "-128/-1", 8'h80, 4'h0, 1'b0, 1'b1, 10);
        wait_done("-128/-1");
        issue(8'hF9, 4'hE, 1'b1, "-7/-2", 8'h03, 4'hF, 1'b0, 1'b0, 10);
        wait_done("-7/-2");

        // New start and operands mid-ITER must not disturb the running division.
        issue(8'd100, 4'd7, 1'b1, "ignored_start", 8'h0E, 4'h2, 1'b0, 1'b0, 10);
        repeat (3) @(negedge clk);
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");

        // Reset sampled while the counter reads 4.
        issue(8'd100, 4'd7, 1'b0, "", 8'h0, 4'h0, 1'b0, 1'b0, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;

        issue(8'd7, 4'd2, 1'b1, "7/2", 8'h03, 4'h1, 1'b0, 1'b0, 10);
        wait_done("7/2");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
